// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan display
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // All segments dark / all anodes disabled
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has a glyph
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - eight-digit multiplexed seven-segment driver with per-frame snapshot
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIV      = 100000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [31:0] snap, snap_n;
  logic        frame_done_n;

  logic [2:0]  hi;
  logic        lz;
  logic [3:0]  nib;
  logic [6:0]  pat;
  logic [7:0]  an_n;

  assign tick = (cnt == CNT_W'(DIV - 1));

  // Digit-slot divider: counts 0..DIV-1 and wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state: advance the digit on tick, reload the snapshot at frame start
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    snap_n       = snap;
    frame_done_n = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          state_n      = SCAN;
          idx_n        = 3'd0;
          snap_n       = data_in;
          frame_done_n = 1'b1;
        end
        SCAN: begin
          if (idx == 3'd7) begin
            idx_n        = 3'd0;
            snap_n       = data_in;
            frame_done_n = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Highest nonzero nibble of the snapshot being shown; 0 when the snapshot is 0
  always_comb begin
    hi = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (snap_n[4*k +: 4] != 4'h0) hi = 3'(k);
    end
  end

  assign lz  = BLANK_LZ && (idx_n > hi);
  assign nib = snap_n[{idx_n, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nibble (nib),
    .seg    (pat)
  );

  // Anode for the upcoming slot: one-hot-low unless blanked
  always_comb begin
    an_n = AN_OFF;
    if (!(blank || lz)) an_n[idx_n] = 1'b0;
  end

  // Scan state and registered outputs; an/seg move together only on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      snap       <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snap       <= snap_n;
      frame_done <= frame_done_n;
      if (tick) begin
        an  <= an_n;
        seg <= pat;
      end
    end
  end

  assign dp = 1'b1;

endmodule
